// File: rtl/pc_sequencer_if.sv
// pc_seq_if: control-unit <-> PC sequencer bundle.
// master = control unit side, slave = pc_sequencer side.
interface pc_seq_if #(
  parameter int ADDR_W = 64
);
  logic              stall;
  logic              branch;
  logic              uncond_branch;
  logic              zero_flag;
  logic              cond_nz;
  logic              br_reg;
  logic              link;
  logic              ret;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] target_reg;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] link_addr;
  logic              redirect;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  modport master (
    output stall, branch, uncond_branch,
    output zero_flag, cond_nz, br_reg,
    output link, ret, offset, target_reg,
    input  pc, link_addr, redirect,
    input  ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, branch, uncond_branch,
    input  zero_flag, cond_nz, br_reg,
    input  link, ret, offset, target_reg,
    output pc, link_addr, redirect,
    output ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered PC with branch/BL/BR/RET redirects and a
// circular return-address stack. Ports: clk, rst_n, bus (pc_seq_if.slave).
module pc_sequencer #(
  parameter int                ADDR_W    = 64,
  parameter int                INC       = 1,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  pc_seq_if.slave bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] INC_V =
    ADDR_W'(INC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  logic              wr_en;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] wr_data;

  logic              taken;
  logic              push;
  logic              ras_hit;
  logic              sel_ret;
  logic              sel_reg;
  logic              sel_rel;
  logic              sel_seq;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] rel_pc;
  logic [ADDR_W-1:0] npc;
  logic [PTR_W-1:0]  top_p;
  logic [CNT_W-1:0]  cnt_p;

  always_comb begin
    taken = bus.uncond_branch
          | (bus.branch & (bus.zero_flag ^ bus.cond_nz));
    // ret+link is a pop-then-push, so ret also
    // qualifies link as a call
    push    = bus.link
            & (taken | bus.br_reg | bus.ret);
    ras_hit = (cnt_q != '0);
    seq_pc  = pc_q + INC_V;
    rel_pc  = pc_q + bus.offset;
  end

  // one-hot selects encode the priority
  always_comb begin
    sel_ret = bus.ret;
    sel_reg = bus.br_reg & ~bus.ret;
    sel_rel = taken & ~bus.br_reg & ~bus.ret;
    sel_seq = ~taken & ~bus.br_reg & ~bus.ret;
  end

  always_comb begin
    npc = seq_pc;
    unique case (1'b1)
      sel_ret: npc = ras_hit ? ras_mem[top_q]
                             : bus.target_reg;
      sel_reg: npc = bus.target_reg;
      sel_rel: npc = rel_pc;
      sel_seq: npc = seq_pc;
      default: npc = seq_pc;
    endcase
  end

  always_comb begin
    top_p   = top_q;
    cnt_p   = cnt_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_ptr  = top_q;
    wr_data = seq_pc;
    pc_d    = pc_q;

    if (!bus.stall) begin
      pc_d = npc;
      if (bus.ret) begin
        if (ras_hit) begin
          top_p = top_q - PTR_W'(1);
          cnt_p = cnt_q - CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      top_d = top_p;
      cnt_d = cnt_p;
      if (push) begin
        wr_en  = 1'b1;
        wr_ptr = top_p + PTR_W'(1);
        top_d  = top_p + PTR_W'(1);
        // full: new top lands on the oldest slot
        if (cnt_p == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_p + CNT_W'(1);
        end
      end
    end

    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      top_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  // entries are don't-care after reset; count
  // alone decides what is valid
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ras_mem[wr_ptr] <= wr_data;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.link_addr = seq_pc;
  assign bus.redirect  = bus.ret | bus.br_reg | taken;
  assign bus.ras_empty = empty_q;
  assign bus.ras_full  = full_q;
  assign bus.ras_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + random stimulus for pc_sequencer,
// checked against a queue-based reference model.
module tb_pc_sequencer;

  localparam int AW    = 64;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  pc_seq_if #(.ADDR_W(AW)) bus ();

  pc_sequencer #(
    .ADDR_W   (AW),
    .INC      (1),
    .RESET_PC ('0),
    .RAS_DEPTH(DEPTH)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] m_pc;
  logic [63:0] m_ras[$];
  bit          m_err;

  logic [63:0] bl_pc [5];
  logic [63:0] sv_pc;
  logic [63:0] sv_la;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
  endtask

  function automatic bit m_taken();
    return bus.uncond_branch |
      (bus.branch & (bus.zero_flag != bus.cond_nz));
  endfunction

  function automatic void m_reset();
    m_pc  = '0;
    m_ras.delete();
    m_err = 0;
  endfunction

  function automatic void m_step();
    logic [63:0] nxt;
    bit tk;
    if (bus.stall) return;
    tk  = m_taken();
    nxt = m_pc + 64'd1;
    if (tk)         nxt = m_pc + bus.offset;
    if (bus.br_reg) nxt = bus.target_reg;
    if (bus.ret) begin
      if (m_ras.size() > 0) nxt = m_ras.pop_back();
      else begin
        nxt   = bus.target_reg;
        m_err = 1;
      end
    end
    if (bus.link && (tk || bus.br_reg || bus.ret)) begin
      m_ras.push_back(m_pc + 64'd1);
      if (m_ras.size() > DEPTH) begin
        void'(m_ras.pop_front());
        m_err = 1;
      end
    end
    m_pc = nxt;
  endfunction

  task automatic set_in(input bit st, input bit br,
                        input bit ub, input bit z,
                        input bit nz, input bit rg,
                        input bit lk, input bit rt,
                        input logic [63:0] off,
                        input logic [63:0] tgt);
    bus.stall         = st;
    bus.branch        = br;
    bus.uncond_branch = ub;
    bus.zero_flag     = z;
    bus.cond_nz       = nz;
    bus.br_reg        = rg;
    bus.link          = lk;
    bus.ret           = rt;
    bus.offset        = off;
    bus.target_reg    = tgt;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ":pc"}, bus.pc, m_pc);
    chk({tag, ":empty"}, 64'(bus.ras_empty),
        64'(m_ras.size() == 0));
    chk({tag, ":full"}, 64'(bus.ras_full),
        64'(m_ras.size() == DEPTH));
    chk({tag, ":err"}, 64'(bus.ras_err), 64'(m_err));
  endtask

  task automatic cyc(input string tag);
    @(negedge clk);
    chk({tag, ":redir"}, 64'(bus.redirect),
        64'(bus.ret | bus.br_reg | m_taken()));
    chk({tag, ":link"}, bus.link_addr, m_pc + 64'd1);
    @(posedge clk);
    m_step();
    #1;
    chk_state(tag);
  endtask

  // called just after a posedge; asserts reset
  // mid-cycle and releases it after the next edge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk_state(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic jump(input logic [63:0] tgt);
    set_in(0, 0, 0, 0, 0, 1, 0, 0, '0, tgt);
    cyc("jmp");
  endtask

  task automatic bl(input logic [63:0] off);
    set_in(0, 0, 1, 0, 0, 0, 1, 0, off, '0);
    cyc("bl");
  endtask

  task automatic rt(input logic [63:0] tgt);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, '0, tgt);
    cyc("ret");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    #2;
    do_reset("rst0");

    for (int i = 1; i <= 3; i++) begin
      cyc("seq");
      chk("seq_pc", bus.pc, 64'(i));
    end

    jump(64'h40);
    chk("pre_rst", bus.pc, 64'h40);
    do_reset("rst_mid");
    chk("rst_pc", bus.pc, 64'h0);
    idle();
    cyc("post_rst");
    chk("post_rst_pc", bus.pc, 64'h1);

    jump(64'h10);
    set_in(0, 1, 0, 1, 0, 0, 0, 0,
           64'hFFFF_FFFF_FFFF_FFFC, '0);
    cyc("cbz");
    chk("cbz_pc", bus.pc, 64'h0C);
    set_in(0, 1, 0, 1, 1, 0, 0, 0,
           64'hFFFF_FFFF_FFFF_FFFC, '0);
    #1;
    chk("cbnz_redir", 64'(bus.redirect), 64'h0);
    cyc("cbnz");
    chk("cbnz_pc", bus.pc, 64'h0D);

    jump(64'h100);
    for (int i = 0; i < 3; i++) bl(64'h100);
    rt('0);
    chk("nest1", bus.pc, 64'h301);
    rt('0);
    chk("nest2", bus.pc, 64'h201);
    rt('0);
    chk("nest3", bus.pc, 64'h101);
    chk("nest_empty", 64'(bus.ras_empty), 64'h1);
    chk("nest_err", 64'(bus.ras_err), 64'h0);

    for (int i = 0; i < 5; i++) begin
      bl_pc[i] = bus.pc;
      bl(64'h100);
    end
    chk("ovf_err", 64'(bus.ras_err), 64'h1);
    for (int k = 0; k < 4; k++) begin
      rt(64'hABC);
      chk("ovf_ret", bus.pc, bl_pc[4-k] + 64'd1);
    end
    rt(64'hABC);
    chk("udf_pc", bus.pc, 64'hABC);
    idle();
    cyc("sticky");
    cyc("sticky");
    chk("err_sticky", 64'(bus.ras_err), 64'h1);
    do_reset("rst_err");
    chk("err_clr", 64'(bus.ras_err), 64'h0);

    jump(64'h500);
    bl(64'h100);
    set_in(0, 0, 1, 0, 0, 1, 0, 1,
           64'h20, 64'h777);
    cyc("prio");
    chk("prio_pc", bus.pc, 64'h501);

    jump(64'h800);
    bl(64'h100);
    bl(64'h100);
    set_in(0, 0, 0, 0, 0, 0, 1, 1, '0, '0);
    cyc("retlink");
    chk("rl_pc", bus.pc, 64'h901);
    rt('0);
    chk("rl_top", bus.pc, 64'hA01);
    rt('0);
    chk("rl_next", bus.pc, 64'h801);

    jump(64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    cyc("wrap");
    chk("wrap_pc", bus.pc, 64'h0);

    jump(64'h2000);
    sv_pc = bus.pc;
    set_in(1, 0, 1, 0, 0, 0, 1, 0, 64'h40, '0);
    cyc("stall");
    cyc("stall");
    chk("stall_pc", bus.pc, sv_pc);
    chk("stall_empty", 64'(bus.ras_empty), 64'h1);
    set_in(0, 0, 1, 0, 0, 0, 1, 0, 64'h40, '0);
    cyc("unstall");
    chk("unstall_pc", bus.pc, sv_pc + 64'h40);
    sv_la = sv_pc + 64'd1;
    rt('0);
    chk("stall_ret", bus.pc, sv_la);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rnd_rst");
      end
      set_in($urandom_range(0, 7) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 1) == 0,
             $urandom_range(0, 1) == 0,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 4) == 0,
             {$urandom, $urandom},
             {$urandom, $urandom});
      cyc("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
